aurora_rx_fifo: RTL and testbench

- Synchronous receive FIFO placed after the Aurora RX user interface.
- Buffers an AXI-Stream input that has no tready (Aurora cannot be back-pressured) and presents it as a full AXI-Stream output with tready.
- Produces low/high watermark flags that the upstream Aurora flow-control logic (NFC/UFC) uses to pause and resume the link partner.

---
 rtl/aurora_rx_fifo_pkg.sv | 32 +++
 rtl/aurora_rx_fifo_core.sv | 69 ++++++
 rtl/aurora_rx_fifo.sv | 114 +++++++++++
 tb/tb_aurora_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aurora_rx_fifo_pkg
// Description : Shared helpers for the Aurora RX FIFO. This package holds the
//               pointer-width function and the entry packing order, which is
//               {tlast, tkeep, tdata} with tdata in the LSBs and tlast in the
//               MSB.
// Revision    : 1.0 - initial release
// ============================================================================
package aurora_rx_fifo_pkg;

  // Packing order inside one FIFO entry: tdata, then tkeep, then tlast.
  localparam int unsigned PACK_TDATA_LSB = 0;

  // Pointer width for a power-of-two depth (minimum of 1 bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The first tkeep bit sits directly above tdata.
  function automatic int unsigned tkeep_lsb(input int unsigned data_w);
    return PACK_TDATA_LSB + data_w;
  endfunction

  // tlast is the MSB of the entry.
  function automatic int unsigned tlast_bit(input int unsigned data_w,
                                            input int unsigned keep_w);
    return PACK_TDATA_LSB + data_w + keep_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_rx_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : aurora_rx_fifo_core
// Description : Generic first-word-fall-through synchronous FIFO. The caller
//               must not request a write while the FIFO is full unless it
//               also requests a read in the same cycle. The caller must not
//               request a read while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_rx_fifo_core
  import aurora_rx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Storage array: reset does not clear it because stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Next used-count from the write/read pair. A simultaneous write and read leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en_i, rd_en_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH; the count is kept one bit wider so that full is distinct from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/aurora_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aurora_rx_fifo
// Description : Receive FIFO that sits behind the Aurora RX user interface.
//               It accepts an AXI-Stream input without tready and presents a
//               full AXI-Stream FWFT output. It also provides low/high
//               watermark flags for NFC/UFC flow control.
//               Defining AURORA_RX_FIFO_OVERFLOW_EN adds a sticky
//               fifo_overflow output, which is set when a beat is dropped
//               because the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_rx_fifo
  import aurora_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned KEEP_W     = DATA_W / 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FIFO_LWM   = 32,
  parameter int unsigned FIFO_HWM   = 56
) (
  input  logic              clk,
  input  logic              rst,            // synchronous, active-low
  output logic              fifo_ready,
  output logic              fifo_below_lwm,
  output logic              fifo_above_hwm,
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
  output logic              fifo_overflow,
`endif
  input  logic [DATA_W-1:0] i_tdata,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_tvalid,
  input  logic              i_tlast,
  output logic [DATA_W-1:0] o_tdata,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              o_tready
);

  localparam int unsigned ENT_W = DATA_W + KEEP_W + 1;
  localparam int unsigned CNT_W = ptr_w(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LWM_C  = CNT_W'(FIFO_LWM);
  localparam logic [CNT_W-1:0] HWM_C  = CNT_W'(FIFO_HWM);

  logic             fifo_ready_q;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;
  logic [CNT_W-1:0] cnt;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  // The ready signal goes low during reset and rises at the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) fifo_ready_q <= 1'b0;
    else      fifo_ready_q <= 1'b1;
  end

  // The read is decided first so that a full FIFO can still accept a write in the same cycle it drains one.
  assign full  = (cnt == FULL_C);
  assign rd_en = ~empty & o_tready;
  assign wr_en = i_tvalid & fifo_ready_q & (~full | rd_en);

  // Pack the input beat unchanged into {tlast, tkeep, tdata}.
  always_comb begin
    wr_entry = '0;
    wr_entry[PACK_TDATA_LSB +: DATA_W]       = i_tdata;
    wr_entry[tkeep_lsb(DATA_W) +: KEEP_W]    = i_tkeep;
    wr_entry[tlast_bit(DATA_W, KEEP_W)]      = i_tlast;
  end

  aurora_rx_fifo_core #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (wr_en),
    .rd_en_i (rd_en),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .cnt_o   (cnt),
    .empty_o (empty)
  );

  assign o_tvalid = ~empty;
  assign o_tdata  = rd_entry[PACK_TDATA_LSB +: DATA_W];
  assign o_tkeep  = rd_entry[tkeep_lsb(DATA_W) +: KEEP_W];
  assign o_tlast  = rd_entry[tlast_bit(DATA_W, KEEP_W)];

  assign fifo_ready     = fifo_ready_q;
  assign fifo_below_lwm = (cnt < LWM_C);
  assign fifo_above_hwm = (cnt > HWM_C);

`ifdef AURORA_RX_FIFO_OVERFLOW_EN
  logic overflow_q;

  // Sticky drop indicator. Only drops caused by a full FIFO set it; reset is the only thing that clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (i_tvalid && fifo_ready_q && full && !rd_en) begin
      overflow_q <= 1'b1;
    end
  end

  assign fifo_overflow = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_rx_fifo
// Description : Scoreboard bench for aurora_rx_fifo using directed traffic.
//               A posedge model pushes every accepted beat into a queue. A
//               negedge monitor pops and compares each handshaked beat, and
//               it also checks flags and stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_rx_fifo;

  localparam int DW    = 8;
  localparam int KW    = 1;
  localparam int EW    = DW + KW + 1;
  localparam int DEPTH = 64;
  localparam int LWM   = 32;
  localparam int HWM   = 56;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_ready;
  logic          fifo_below_lwm;
  logic          fifo_above_hwm;
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
  logic          fifo_overflow;
`endif
  logic [DW-1:0] i_tdata  = '0;
  logic [KW-1:0] i_tkeep  = '0;
  logic          i_tvalid = 1'b0;
  logic          i_tlast  = 1'b0;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_tready = 1'b0;

  aurora_rx_fifo #(
    .DATA_W     (DW),
    .KEEP_W     (KW),
    .FIFO_DEPTH (DEPTH),
    .FIFO_LWM   (LWM),
    .FIFO_HWM   (HWM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_ready     (fifo_ready),
    .fifo_below_lwm (fifo_below_lwm),
    .fifo_above_hwm (fifo_above_hwm),
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
    .fifo_overflow  (fifo_overflow),
`endif
    .i_tdata        (i_tdata),
    .i_tkeep        (i_tkeep),
    .i_tvalid       (i_tvalid),
    .i_tlast        (i_tlast),
    .o_tdata        (o_tdata),
    .o_tkeep        (o_tkeep),
    .o_tvalid       (o_tvalid),
    .o_tlast        (o_tlast),
    .o_tready       (o_tready)
  );

  always #5 clk = ~clk;

  int            vectors     = 0;
  int            miscompares = 0;
  int            n_out       = 0;
  logic [EW-1:0] exp_q [$];
  int            m_cnt   = 0;
  bit            m_ready = 1'b0;
  bit            m_ovf   = 1'b0;
  logic [DW-1:0] seq     = '0;
  bit            prev_stall = 1'b0;
  logic [EW-1:0] prev_ent   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from its own occupancy and queues expected beats.
  always @(posedge clk) begin
    bit rd;
    bit wr;
    if (!rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      rd = (m_cnt != 0) && o_tready;
      wr = i_tvalid && m_ready && ((m_cnt < DEPTH) || rd);
      if (i_tvalid && m_ready && (m_cnt == DEPTH) && !rd) m_ovf = 1'b1;
      if (wr) exp_q.push_back({i_tlast, i_tkeep, i_tdata});
      m_cnt   = m_cnt + int'(wr) - int'(rd);
      m_ready = 1'b1;
    end
  end

  // Monitor: compare handshaked beats, flags and stall stability away from the active edge.
  always @(negedge clk) begin
    if (rst && prev_stall) begin
      chk("stall_tvalid", {31'd0, o_tvalid}, 32'd1);
      chk("stall_hold", {22'd0, o_tlast, o_tkeep, o_tdata}, {22'd0, prev_ent});
    end
    if (rst && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        chk("beat", {22'd0, o_tlast, o_tkeep, o_tdata}, {22'd0, exp_q[0]});
        void'(exp_q.pop_front());
        n_out++;
      end
    end
    chk("o_tvalid", {31'd0, o_tvalid}, {31'd0, m_cnt != 0});
    chk("below_lwm", {31'd0, fifo_below_lwm}, {31'd0, m_cnt < LWM});
    chk("above_hwm", {31'd0, fifo_above_hwm}, {31'd0, m_cnt > HWM});
    chk("fifo_ready", {31'd0, fifo_ready}, {31'd0, m_ready});
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
    chk("overflow", {31'd0, fifo_overflow}, {31'd0, m_ovf});
`endif
    prev_stall = rst && o_tvalid && !o_tready;
    prev_ent   = {o_tlast, o_tkeep, o_tdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for exactly one edge. Back-to-back calls give a continuous stream.
  task automatic send(input logic last, input logic [KW-1:0] keep);
    i_tvalid = 1'b1;
    i_tdata  = seq;
    i_tkeep  = keep;
    i_tlast  = last;
    seq      = seq + 8'd1;
    tick();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    o_tready = 1'b1;
    while ((m_cnt != 0 || o_tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, n < budget}, 32'd1);
  endtask

  initial begin
    int base;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rst_ready", {31'd0, fifo_ready}, 32'd0);
    chk("rst_below", {31'd0, fifo_below_lwm}, 32'd1);
    chk("rst_above", {31'd0, fifo_above_hwm}, 32'd0);
    rst = 1'b1;
    tick();
    chk("ready_rise", {31'd0, fifo_ready}, 32'd1);

    // Pass-through: 5 frames x 40 beats with the sink always ready.
    o_tready = 1'b1;
    base = n_out;
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < 40; b++)
        send(b == 39, KW'($urandom_range(0, 1)));
    drain(100);
    chk("pass_count", n_out - base, 200);

    // Fill: 200 beats with the sink stalled. Beats 65 and later are dropped.
    o_tready = 1'b0;
    base = n_out;
    for (int k = 1; k <= 200; k++) begin
      send(k % 16 == 0, 1'b1);
      if (k == 31) chk("fill_below31", {31'd0, fifo_below_lwm}, 32'd1);
      if (k == 32) chk("fill_below32", {31'd0, fifo_below_lwm}, 32'd0);
      if (k == 56) chk("fill_above56", {31'd0, fifo_above_hwm}, 32'd0);
      if (k == 57) chk("fill_above57", {31'd0, fifo_above_hwm}, 32'd1);
    end
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
    chk("fill_overflow", {31'd0, fifo_overflow}, 32'd1);
`endif
    drain(300);
    chk("fill_count", n_out - base, 64);

    // Watermark: fill to 57, then drain 26 beats down to 31.
    o_tready = 1'b0;
    for (int k = 0; k < 57; k++) send(1'b0, 1'b1);
    chk("wm_above57", {31'd0, fifo_above_hwm}, 32'd1);
    o_tready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (i == 24) chk("wm_drain32", {31'd0, fifo_below_lwm}, 32'd0);
    end
    o_tready = 1'b0;
    chk("wm_drain31", {31'd0, fifo_below_lwm}, 32'd1);

    // Full with simultaneous read and write: top up to 64, then stream for 10 cycles.
    for (int k = 0; k < 33; k++) send(1'b0, 1'b1);
    chk("full_above", {31'd0, fifo_above_hwm}, 32'd1);
    base = n_out;
    o_tready = 1'b1;
    for (int k = 0; k < 10; k++) send(k == 9, 1'b1);
    o_tready = 1'b0;
    chk("full_rw_above", {31'd0, fifo_above_hwm}, 32'd1);
    send(1'b0, 1'b1);
    drain(200);
    chk("full_rw_count", n_out - base, 74);

    // Reset mid-operation with 20 entries stored.
    o_tready = 1'b0;
    for (int k = 0; k < 20; k++) send(1'b0, 1'b1);
    rst = 1'b0;
    tick();
    chk("mid_rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("mid_rst_ready", {31'd0, fifo_ready}, 32'd0);
    chk("mid_rst_below", {31'd0, fifo_below_lwm}, 32'd1);
    chk("mid_rst_above", {31'd0, fifo_above_hwm}, 32'd0);
`ifdef AURORA_RX_FIFO_OVERFLOW_EN
    chk("mid_rst_overflow", {31'd0, fifo_overflow}, 32'd0);
`endif
    rst = 1'b1;
    send(1'b1, 1'b1);
    chk("post_rst_ready", {31'd0, fifo_ready}, 32'd1);
    chk("drop_not_ready", {31'd0, o_tvalid}, 32'd0);

    // Backpressure: a 40-beat frame with a randomly toggling sink.
    base = n_out;
    for (int b = 0; b < 40; b++) begin
      o_tready = 1'($urandom_range(0, 1));
      send(b == 39, KW'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) begin
      o_tready = 1'($urandom_range(0, 1));
      tick();
    end
    drain(200);
    chk("bp_count", n_out - base, 40);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
